// File: rtl/alu_sys_pkg.sv
// Shared codes for the ALU command path: frame headers, sequencer state
// encoding and the ALU function unit-select field.
package alu_sys_pkg;

    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_GET_A    = 3'd1;
    localparam logic [STATE_W-1:0] ST_GET_B    = 3'd2;
    localparam logic [STATE_W-1:0] ST_GET_FUN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ALU_RUN  = 3'd4;
    localparam logic [STATE_W-1:0] ST_ALU_WAIT = 3'd5;
    localparam logic [STATE_W-1:0] ST_SEND_LO  = 3'd6;
    localparam logic [STATE_W-1:0] ST_SEND_HI  = 3'd7;

    // ALU_FUN[3:2] selects the unit, ALU_FUN[1:0] the operation within it
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of RX, ALU and TX-FIFO signals around the command sequencer.
// master = the sequencer, slave = the surrounding RX/ALU/FIFO side.
interface alu_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    OUT_VALID;
    logic                    FIFO_FULL;
    logic [DATA_WIDTH-1:0]   OP_A;
    logic [DATA_WIDTH-1:0]   OP_B;
    logic [3:0]              ALU_FUN;
    logic                    ALU_EN;
    logic                    CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    BUSY;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, FIFO_FULL,
        output OP_A, OP_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, BUSY
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, FIFO_FULL,
        input  OP_A, OP_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, BUSY
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Parses ALU command frames from the RX byte stream, runs the ALU once per
// frame and streams the 16-bit result to the TX FIFO, low byte first.
module alu_cmd_sequencer
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ALU_OP_CMD  = DATA_WIDTH'(CMD_ALU_OP),
    parameter logic [DATA_WIDTH-1:0] ALU_NOP_CMD = DATA_WIDTH'(CMD_ALU_NOP),
    parameter int TIMEOUT = 15
) (
    input logic CLK,
    input logic RST,
    alu_cmd_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [STATE_W-1:0]      state;
    logic [STATE_W-1:0]      state_nxt;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic [3:0]              fun;
    logic [2*DATA_WIDTH-1:0] result;
    logic [CNT_W-1:0]        cnt;
    logic                    timed_out;

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == ALU_OP_CMD)       state_nxt = ST_GET_A;
                    else if (bus.RX_P_DATA == ALU_NOP_CMD) state_nxt = ST_GET_FUN;
                end
            end
            ST_GET_A:    if (bus.RX_D_VLD) state_nxt = ST_GET_B;
            ST_GET_B:    if (bus.RX_D_VLD) state_nxt = ST_GET_FUN;
            ST_GET_FUN:  if (bus.RX_D_VLD) state_nxt = ST_ALU_RUN;
            ST_ALU_RUN:  state_nxt = ST_ALU_WAIT;
            ST_ALU_WAIT: begin
                if (bus.OUT_VALID)  state_nxt = ST_SEND_LO;
                else if (timed_out) state_nxt = ST_IDLE;
            end
            ST_SEND_LO:  if (!bus.FIFO_FULL) state_nxt = ST_SEND_HI;
            ST_SEND_HI:  if (!bus.FIFO_FULL) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            fun    <= '0;
            result <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_GET_A && bus.RX_D_VLD)   op_a <= bus.RX_P_DATA;
            if (state == ST_GET_B && bus.RX_D_VLD)   op_b <= bus.RX_P_DATA;
            if (state == ST_GET_FUN && bus.RX_D_VLD) fun  <= bus.RX_P_DATA[3:0];
            if (state == ST_ALU_WAIT && bus.OUT_VALID) result <= bus.ALU_OUT;
            // counter only runs while waiting, so every ALU_WAIT entry starts from zero
            if (state == ST_ALU_WAIT) cnt <= cnt + 1'b1;
            else                      cnt <= '0;
        end
    end

    assign bus.OP_A        = op_a;
    assign bus.OP_B        = op_b;
    assign bus.ALU_FUN     = fun;
    assign bus.ALU_EN      = (state == ST_ALU_RUN);
    assign bus.CLK_GATE_EN = (state == ST_ALU_RUN) || (state == ST_ALU_WAIT);
    assign bus.TX_P_DATA   = (state == ST_SEND_HI) ? result[2*DATA_WIDTH-1:DATA_WIDTH]
                                                   : result[DATA_WIDTH-1:0];
    assign bus.TX_D_VLD    = ((state == ST_SEND_LO) || (state == ST_SEND_HI)) && !bus.FIFO_FULL;
    assign bus.BUSY        = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed frames plus randomized
// frames, compared against a frame-level model of operands and TX bytes.
module tb_alu_cmd_sequencer;

    localparam int TMO = 15;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_cmd_sequencer_if #(.DATA_WIDTH(8)) bus();

    alu_cmd_sequencer #(
        .DATA_WIDTH (8),
        .ALU_OP_CMD (8'hCC),
        .ALU_NOP_CMD(8'hDD),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // frame-level model: operand/function registers as the frames define them
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [3:0] m_f = 4'h0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         en_cyc, en_cnt, ov_cyc, first_tx, idle_cyc, stall_cnt;
    logic [7:0] en_a, en_b;
    logic [3:0] en_f;
    logic       en_gate;
    bit         budget_hit;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        bus.ALU_OUT   = 16'h0000;
        bus.OUT_VALID = 1'b0;
        bus.FIFO_FULL = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_D_VLD  = 1'b1;
        bus.RX_P_DATA = b;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    // update the model from a frame the way the command format defines it
    task automatic model_frame();
        int h;
        h = 0;
        while (h < rx_q.size() && rx_q[h] != 8'hCC && rx_q[h] != 8'hDD) h++;
        if (h < rx_q.size() && rx_q[h] == 8'hCC) begin
            m_a = rx_q[h+1];
            m_b = rx_q[h+2];
            m_f = rx_q[h+3][3:0];
        end else if (h < rx_q.size()) begin
            m_f = rx_q[h+1][3:0];
        end
    endtask

    // Plays rx_q into the DUT, acts as ALU (OUT_VALID ov_delay cycles after
    // ALU_EN, 0 = never) and TX FIFO (full for full_cycles on entering send).
    // Cycle 0 is the cycle carrying the last RX byte.
    task automatic drive_frame(input int ov_delay, input logic [15:0] aluv,
                               input int full_cycles, input bit rx_noise);
        tx_q.delete();
        en_cyc = -1; en_cnt = 0; ov_cyc = -1; first_tx = -1; idle_cyc = -1;
        stall_cnt = 0; budget_hit = 1'b0; en_gate = 1'b0;
        en_a = 8'h00; en_b = 8'h00; en_f = 4'h0;
        foreach (rx_q[i]) send_byte(rx_q[i]);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            bus.OUT_VALID = (en_cyc >= 0 && ov_delay > 0 && cyc == en_cyc + ov_delay);
            if (bus.OUT_VALID) ov_cyc = cyc;
            bus.ALU_OUT   = aluv;
            bus.FIFO_FULL = (ov_cyc >= 0 && cyc > ov_cyc && cyc <= ov_cyc + full_cycles);
            bus.RX_D_VLD  = rx_noise && bus.FIFO_FULL;
            bus.RX_P_DATA = 8'($urandom);
            #1;
            if (bus.ALU_EN) begin
                en_cnt++;
                if (en_cyc < 0) begin
                    en_cyc = cyc; en_a = bus.OP_A; en_b = bus.OP_B;
                    en_f = bus.ALU_FUN; en_gate = bus.CLK_GATE_EN;
                end
            end
            if (bus.TX_D_VLD) begin
                tx_q.push_back(bus.TX_P_DATA);
                if (first_tx < 0) first_tx = cyc;
            end else if (bus.FIFO_FULL && bus.BUSY) begin
                stall_cnt++;
            end
            if (en_cyc >= 0 && !bus.BUSY) begin
                idle_cyc = cyc;
                break;
            end
            tick();
        end
        if (idle_cyc < 0) budget_hit = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.OP_A !== 8'h00) begin n_err++; $display("FAIL reset_op_a got %h want 00", bus.OP_A); end
        n_cmp++; if (bus.OP_B !== 8'h00) begin n_err++; $display("FAIL reset_op_b got %h want 00", bus.OP_B); end
        n_cmp++; if (bus.ALU_FUN !== 4'h0) begin n_err++; $display("FAIL reset_fun got %h want 0", bus.ALU_FUN); end
        n_cmp++;
        if ({bus.ALU_EN, bus.CLK_GATE_EN, bus.TX_D_VLD, bus.BUSY, bus.TX_P_DATA} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs got en=%b gate=%b txv=%b busy=%b txd=%h want all 0",
                     bus.ALU_EN, bus.CLK_GATE_EN, bus.TX_D_VLD, bus.BUSY, bus.TX_P_DATA);
        end
        RST = 1'b1;
        tick();
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_release_busy got %b want 0", bus.BUSY); end
    endtask

    task automatic test_op_frame();
        logic [15:0] aluv;
        aluv = 16'h0008;
        rx_q = {8'hCC, 8'h05, 8'h03, 8'h00};
        model_frame();
        drive_frame(1, aluv, 0, 1'b0);
        n_cmp++; if (budget_hit) begin n_err++; $display("FAIL op_frame_done got timeout want idle"); end
        n_cmp++;
        if (en_cnt != 1 || en_gate !== 1'b1) begin
            n_err++; $display("FAIL op_frame_alu_en got cnt=%0d gate=%b want 1/1", en_cnt, en_gate);
        end
        n_cmp++;
        if ({en_a, en_b, en_f} !== {m_a, m_b, m_f}) begin
            n_err++; $display("FAIL op_frame_operands got %h %h %h want %h %h %h", en_a, en_b, en_f, m_a, m_b, m_f);
        end
        n_cmp++;
        if (tx_q.size() != 2 || tx_q[0] !== aluv[7:0] || tx_q[1] !== aluv[15:8]) begin
            n_err++; $display("FAIL op_frame_tx got %p want %h %h", tx_q, aluv[7:0], aluv[15:8]);
        end
        n_cmp++; if (first_tx != 3) begin n_err++; $display("FAIL op_frame_latency got %0d want 3", first_tx); end
        n_cmp++; if (idle_cyc != first_tx + 2) begin n_err++; $display("FAIL op_frame_busy_low got %0d want %0d", idle_cyc, first_tx + 2); end
    endtask

    task automatic test_nop_frame();
        logic [15:0] aluv;
        aluv = 16'h0001;
        rx_q = {8'hDD, 8'h01};
        model_frame();
        drive_frame(1, aluv, 0, 1'b0);
        n_cmp++;
        if ({en_a, en_b, en_f} !== {8'h05, 8'h03, 4'h1}) begin
            n_err++; $display("FAIL nop_frame_operands got %h %h %h want 05 03 1", en_a, en_b, en_f);
        end
        n_cmp++;
        if (tx_q.size() != 2 || tx_q[0] !== aluv[7:0] || tx_q[1] !== aluv[15:8]) begin
            n_err++; $display("FAIL nop_frame_tx got %p want %h %h", tx_q, aluv[7:0], aluv[15:8]);
        end
        n_cmp++; if (first_tx != 3) begin n_err++; $display("FAIL nop_frame_latency got %0d want 3", first_tx); end
    endtask

    task automatic test_timeout();
        int bad;
        rx_q = {8'hCC, 8'hFF, 8'h02, 8'h0E};
        model_frame();
        drive_frame(0, 16'hBEEF, 0, 1'b0);
        n_cmp++; if (en_f !== 4'hE) begin n_err++; $display("FAIL timeout_fun got %h want e", en_f); end
        n_cmp++; if (tx_q.size() != 0) begin n_err++; $display("FAIL timeout_tx got %0d bytes want 0", tx_q.size()); end
        n_cmp++;
        if (idle_cyc != en_cyc + 1 + TMO) begin
            n_err++; $display("FAIL timeout_idle_cycle got %0d want %0d", idle_cyc, en_cyc + 1 + TMO);
        end
        // late result strobes arrive while idle: nothing may happen
        bad = 0;
        bus.ALU_OUT = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            bus.OUT_VALID = 1'b1;
            tick();
            if (bus.BUSY || bus.TX_D_VLD || bus.ALU_EN) bad++;
        end
        idle_inputs();
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL late_out_valid got %0d active cycles want 0", bad); end
    endtask

    task automatic test_fifo_stall();
        logic [15:0] aluv;
        aluv = 16'($urandom);
        rx_q = {8'hCC, 8'($urandom), 8'($urandom), 8'($urandom)};
        model_frame();
        drive_frame(1, aluv, 4, 1'b1);
        n_cmp++; if (stall_cnt != 4) begin n_err++; $display("FAIL stall_cycles got %0d want 4", stall_cnt); end
        n_cmp++; if (first_tx != 7) begin n_err++; $display("FAIL stall_first_tx got %0d want 7", first_tx); end
        n_cmp++;
        if (tx_q.size() != 2 || tx_q[0] !== aluv[7:0] || tx_q[1] !== aluv[15:8]) begin
            n_err++; $display("FAIL stall_tx got %p want %h %h", tx_q, aluv[7:0], aluv[15:8]);
        end
        n_cmp++;
        if ({bus.OP_A, bus.OP_B, bus.ALU_FUN, bus.BUSY} !== {m_a, m_b, m_f, 1'b0}) begin
            n_err++; $display("FAIL stall_rx_noise got %h %h %h busy=%b want %h %h %h busy=0",
                              bus.OP_A, bus.OP_B, bus.ALU_FUN, bus.BUSY, m_a, m_b, m_f);
        end
    endtask

    task automatic test_stray();
        int bad;
        send_byte(8'h7A);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.BUSY || bus.ALU_EN) bad++;
            tick();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stray_state got %0d busy cycles want 0", bad); end
        n_cmp++;
        if ({bus.OP_A, bus.OP_B, bus.ALU_FUN} !== {m_a, m_b, m_f}) begin
            n_err++; $display("FAIL stray_operands got %h %h %h want %h %h %h",
                              bus.OP_A, bus.OP_B, bus.ALU_FUN, m_a, m_b, m_f);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        send_byte(8'hCC);
        send_byte(8'h11);
        n_cmp++; if (bus.OP_A !== 8'h11) begin n_err++; $display("FAIL midframe_op_a_loaded got %h want 11", bus.OP_A); end
        RST = 1'b0;
        #2;
        m_a = 8'h00; m_b = 8'h00; m_f = 4'h0;
        n_cmp++;
        if ({bus.OP_A, bus.BUSY} !== {m_a, 1'b0}) begin
            n_err++; $display("FAIL midframe_async_reset got op_a=%h busy=%b want 00/0", bus.OP_A, bus.BUSY);
        end
        tick();
        RST = 1'b1;
        tick();
        send_byte(8'h22);
        send_byte(8'h03);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.TX_D_VLD || bus.ALU_EN || bus.BUSY) bad++;
            tick();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL midframe_no_activity got %0d active cycles want 0", bad); end
        n_cmp++;
        if ({bus.OP_A, bus.OP_B} !== {m_a, m_b}) begin
            n_err++; $display("FAIL midframe_operands got %h %h want %h %h", bus.OP_A, bus.OP_B, m_a, m_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] aluv;
        logic [7:0]  stray;
        int          d, full;
        for (int it = 0; it < 20; it++) begin
            rx_q.delete();
            if ($urandom_range(0, 1) == 1) begin
                do stray = 8'($urandom); while (stray == 8'hCC || stray == 8'hDD);
                rx_q.push_back(stray);
            end
            if ($urandom_range(0, 2) == 0) begin
                rx_q.push_back(8'hDD);
                rx_q.push_back(8'($urandom));
            end else begin
                rx_q.push_back(8'hCC);
                for (int k = 0; k < 3; k++) rx_q.push_back(8'($urandom));
            end
            model_frame();
            aluv = 16'($urandom);
            d    = $urandom_range(1, 6);
            full = $urandom_range(0, 3);
            drive_frame(d, aluv, full, 1'b1);
            n_cmp++;
            if (budget_hit || en_cnt != 1) begin
                n_err++; $display("FAIL rand%0d_alu_en got cnt=%0d stuck=%b want 1/0", it, en_cnt, budget_hit);
            end
            n_cmp++;
            if ({en_a, en_b, en_f} !== {m_a, m_b, m_f}) begin
                n_err++; $display("FAIL rand%0d_operands got %h %h %h want %h %h %h", it, en_a, en_b, en_f, m_a, m_b, m_f);
            end
            n_cmp++;
            if (tx_q.size() != 2 || tx_q[0] !== aluv[7:0] || tx_q[1] !== aluv[15:8]) begin
                n_err++; $display("FAIL rand%0d_tx got %p want %h %h", it, tx_q, aluv[7:0], aluv[15:8]);
            end
            n_cmp++;
            if (first_tx != 2 + d + full) begin
                n_err++; $display("FAIL rand%0d_latency got %0d want %0d", it, first_tx, 2 + d + full);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_op_frame();
        test_nop_frame();
        test_timeout();
        test_fifo_stall();
        test_stray();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want summary before 200000ns");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of RX/TX data and ALU operands.
REQ-002 Parameter ALU_OP_CMD, default 8'hCC, frame header: operand A, operand B, function follow.
REQ-003 Parameter ALU_NOP_CMD, default 8'hDD, frame header: function follows, stored operands reused.
REQ-004 Parameter TIMEOUT, default 15, max cycles waited for OUT_VALID after ALU_EN.
REQ-005 CLK  in  1  system clock, all state on rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 RX_P_DATA  in  8  received byte.
REQ-008 RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid.
REQ-009 ALU_OUT  in  16  ALU result.
REQ-010 OUT_VALID  in  1  ALU result valid strobe.
REQ-011 FIFO_FULL  in  1  TX FIFO cannot accept a byte.
REQ-012 OP_A  out  8  operand A register.
REQ-013 OP_B  out  8  operand B register.
REQ-014 ALU_FUN  out  4  [3:2] unit select (00 arith, 01 logic, 10 compare, 11 shift), [1:0] operation.
REQ-015 ALU_EN  out  1  one-cycle ALU start strobe.
REQ-016 CLK_GATE_EN  out  1  ALU clock-gate enable.
REQ-017 TX_P_DATA  out  8  byte to TX FIFO.
REQ-018 TX_D_VLD  out  1  one-cycle write strobe to TX FIFO.
REQ-019 BUSY  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, SEND_LO, SEND_HI.
REQ-021 IDLE: RX_D_VLD with ALU_OP_CMD -> GET_A; with ALU_NOP_CMD -> GET_FUN; any other byte SHALL be discarded, stay IDLE.
REQ-022 GET_A/GET_B: next RX_D_VLD byte SHALL load OP_A/OP_B, advance to GET_B/GET_FUN.
REQ-023 GET_FUN: next RX_D_VLD byte SHALL load ALU_FUN from bits [3:0] (bits [7:4] ignored), advance to ALU_RUN.
REQ-024 ALU_RUN: ALU_EN and CLK_GATE_EN SHALL be high for exactly one cycle, then ALU_WAIT.
REQ-025 ALU_WAIT: CLK_GATE_EN high; OUT_VALID SHALL capture ALU_OUT into a 16-bit result register and go to SEND_LO.
REQ-026 ALU_WAIT: timeout counter cleared on entry; OUT_VALID absent for TIMEOUT cycles -> IDLE, no TX bytes, result register unchanged.
REQ-027 SEND_LO: with FIFO_FULL low, TX_P_DATA = result[7:0], TX_D_VLD high one cycle, go SEND_HI; FIFO_FULL high SHALL stall with TX_D_VLD low.
REQ-028 SEND_HI: same rule with result[15:8], then IDLE; FIFO_FULL stalls indefinitely.
REQ-029 RX_D_VLD in ALU_RUN, ALU_WAIT, SEND_LO, SEND_HI SHALL be dropped without state effect.
REQ-030 OP_A/OP_B/ALU_FUN SHALL hold values between frames; ALU_NOP_CMD frames reuse them.
REQ-031 OUT_VALID outside ALU_WAIT SHALL be ignored.
REQ-032 Total latency, last RX byte to first TX_D_VLD, SHALL be 3 cycles when OUT_VALID follows ALU_EN by one cycle and FIFO_FULL is low.

Reset
REQ-033 RST low SHALL force IDLE and clear OP_A, OP_B, ALU_FUN, result register, timeout counter, and all outputs to 0, asynchronously.
REQ-034 Reset mid-frame or mid-send SHALL abandon the frame; no further TX_D_VLD until a new complete frame.

Structure
REQ-035 Command codes, state encoding and unit-select codes SHALL live in shared package alu_sys_pkg.
REQ-036 Single module, one FSM; no sub-module (timeout counter and result register inline).

Verification
REQ-037 Frame CC,05,03,00 with OUT_VALID one cycle after ALU_EN, ALU_OUT=0x0008 -> TX bytes 08 then 00, BUSY low after.
REQ-038 Then frame DD,01, ALU_OUT=0x0001 -> ALU_FUN=1, OP_A=05, OP_B=03 unchanged, TX bytes 01,00.
REQ-039 Frame CC,FF,02,0E, OUT_VALID withheld 20 cycles -> return to IDLE after 15 cycles in ALU_WAIT, no TX_D_VLD.
REQ-040 FIFO_FULL high 4 cycles on entry to SEND_LO -> TX_D_VLD low 4 cycles, then bytes sent in order.
REQ-041 RST low during GET_B of frame CC,11,... -> OP_A=00, IDLE; bytes 22,03 after reset discarded; no TX.
REQ-042 Stray byte 7A in IDLE, and RX bytes during SEND_LO -> ignored, state/operands unchanged.
